// File: rtl/envelope_generator_pkg.sv
// ---------------------------------------------------------------------------
// envelope_generator_pkg
//   Shared definitions for the per-voice ADSR envelope generator:
//   state encodings, amplitude limits and the rate-to-period helper.
// ---------------------------------------------------------------------------
package envelope_generator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam logic [7:0] AMP_MAX = 8'd255;
    localparam logic [7:0] AMP_MIN = 8'd0;

    // Step period in clocks for a 4-bit rate nibble: (rate+1)*prescale.
    function automatic logic [15:0] rate_period(input logic [3:0]  rate,
                                                input int unsigned prescale);
        logic [31:0] p;
        p = ({28'd0, rate} + 32'd1) * prescale;
        return p[15:0];
    endfunction

endpackage

// File: rtl/envelope_rate_timer.sv
// ---------------------------------------------------------------------------
// envelope_rate_timer
//   Free-running step timer for the envelope. Counts clocks and raises a
//   one-cycle tick when the count reaches period-1, then restarts from 0.
//   Ports:
//     clk    - system clock
//     rst    - asynchronous active-high reset (count -> 0)
//     clear  - synchronous restart of the count (used on state transitions)
//     period - step period in clocks, sampled live
//     tick   - high for the cycle in which the count sits at period-1
// ---------------------------------------------------------------------------
module envelope_rate_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [15:0] period,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Greater-or-equal so a rate shortened mid-step ends the step at the
    // next compare instead of running the counter round its full range.
    assign tick = (cnt_q >= (period - 16'd1));

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/envelope_generator.sv
// ---------------------------------------------------------------------------
// envelope_generator
//   Per-voice ADSR amplitude shaper. Runs an 8-bit ADSR envelope from a
//   level-sensitive gate and scales the unsigned 12-bit waveform sample by
//   it: dout = (din * amplitude) >> 8, registered.
//   Ports:
//     clk       - system clock
//     rst       - asynchronous active-high reset
//     gate      - note on (1) / note off (0)
//     attack    - attack rate nibble
//     decay     - decay rate nibble (also used for sustain-level tracking)
//     sustain   - sustain level nibble, level = {sustain,sustain}
//     rel       - release rate nibble
//     din       - unsigned waveform sample
//     dout      - registered scaled sample
//     amplitude - current envelope value (registered)
//     state     - current ADSR state encoding
// ---------------------------------------------------------------------------
module envelope_generator
    import envelope_generator_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gate,
    input  logic [3:0]  attack,
    input  logic [3:0]  decay,
    input  logic [3:0]  sustain,
    input  logic [3:0]  rel,
    input  logic [11:0] din,
    output logic [11:0] dout,
    output logic [7:0]  amplitude,
    output logic [2:0]  state
);

    env_state_t  state_q, state_d;
    logic [7:0]  amp_q, amp_d;
    logic [11:0] dout_q, dout_d;

    logic [3:0]  rate_sel;
    logic [15:0] period;
    logic        tick;
    logic        timer_clear;
    logic [7:0]  level;

    assign level = {sustain, sustain};

    always_comb begin
        case (state_q)
            ST_ATTACK:             rate_sel = attack;
            ST_DECAY, ST_SUSTAIN:  rate_sel = decay;
            default:               rate_sel = rel;
        endcase
    end

    assign period = rate_period(rate_sel, PRESCALE);

    // Restarting the timer on any transition also discards a tick that
    // lands on the same clock, since the transition branch wins below.
    assign timer_clear = (state_d != state_q);

    envelope_rate_timer u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .period (period),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        case (state_q)
            ST_IDLE: begin
                amp_d = AMP_MIN;
                if (gate) begin
                    state_d = ST_ATTACK;
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (tick) begin
                    if (amp_q >= (AMP_MAX - 8'd1)) begin
                        amp_d   = AMP_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        amp_d = amp_q + 8'd1;
                    end
                end
            end
            ST_DECAY: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (amp_q <= level) begin
                    state_d = ST_SUSTAIN;
                end else if (tick) begin
                    amp_d = amp_q - 8'd1;
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_d = ST_RELEASE;
                end else if (tick && (amp_q > level)) begin
                    amp_d = amp_q - 8'd1;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    state_d = ST_ATTACK;
                end else if (amp_q == AMP_MIN) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    amp_d = amp_q - 8'd1;
                    // The step that reaches zero also lands in IDLE.
                    if (amp_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                amp_d   = AMP_MIN;
            end
        endcase
    end

    assign dout_d = 12'(({8'd0, din} * {12'd0, amp_q}) >> 8);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            amp_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            dout_q  <= dout_d;
        end
    end

    assign dout      = dout_q;
    assign amplitude = amp_q;
    assign state     = state_q;

endmodule

// File: tb/tb_envelope_generator.sv
// ---------------------------------------------------------------------------
// tb_envelope_generator
//   Directed bench for envelope_generator with PRESCALE=16. Inputs change
//   and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_envelope_generator;

    logic        clk;
    logic        rst;
    logic        gate;
    logic [3:0]  attack;
    logic [3:0]  decay;
    logic [3:0]  sustain;
    logic [3:0]  rel;
    logic [11:0] din;
    logic [11:0] dout;
    logic [7:0]  amplitude;
    logic [2:0]  state;

    int passed = 0;
    int total  = 0;

    envelope_generator #(.PRESCALE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .gate      (gate),
        .attack    (attack),
        .decay     (decay),
        .sustain   (sustain),
        .rel       (rel),
        .din       (din),
        .dout      (dout),
        .amplitude (amplitude),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        gate;
        logic [3:0]  att;
        logic [3:0]  dec;
        logic [3:0]  sus;
        logic [3:0]  rel;
        logic [11:0] din;
        int          cyc;
        int          st;
        int          amp;
        int          dout;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic chk_out(input string nm, input int st, input int amp, input int dt);
        chk({nm, ".state"}, int'(state), st);
        chk({nm, ".amp"}, int'(amplitude), amp);
        chk({nm, ".dout"}, int'(dout), dt);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input string nm, input bit on_amp, input int val,
                              input int unsigned max);
        bit hit;
        hit = 1'b0;
        for (int unsigned i = 0; i < max && !hit; i++) begin
            @(negedge clk);
            if (on_amp ? (int'(amplitude) == val) : (int'(state) == val)) hit = 1'b1;
        end
        total++;
        if (hit) passed++;
        else $display("FAIL %s: value %0d not reached within %0d clks", nm, val, max);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        //        gate att dec sus rel din  cyc   st amp  dout
        tbl[0]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    1, 0,   0};
        tbl[1]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 16,   1, 1,   0};
        tbl[2]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 16,   1, 2,   15};
        tbl[3]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 4047, 1, 254, 4063};
        tbl[4]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    2, 255, 4063};
        tbl[5]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    2, 255, 4079};
        tbl[6]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 31,   2, 254, 4079};
        tbl[7]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 3775, 2, 137, 2191};
        tbl[8]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    2, 136, 2191};
        tbl[9]  = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    3, 136, 2175};
        tbl[10] = '{1'b1, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 500,  3, 136, 2175};
        tbl[11] = '{1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    4, 136, 2175};
        tbl[12] = '{1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 16,   4, 135, 2175};
        tbl[13] = '{1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 2159, 4, 1,   15};
        tbl[14] = '{1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    0, 0,   15};
        tbl[15] = '{1'b0, 4'd0, 4'd1, 4'd8, 4'd0, 12'd4095, 1,    0, 0,   0};

        // Reset held with gate high
        rst = 1'b1; gate = 1'b1; attack = 4'd0; decay = 4'd1;
        sustain = 4'd8; rel = 4'd0; din = 12'd4095;
        run(3);
        chk_out("reset", 0, 0, 0);
        run(100);
        chk_out("reset_hold", 0, 0, 0);

        // Full ADSR cycle from the vector table
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            gate = tbl[i].gate; attack = tbl[i].att; decay = tbl[i].dec;
            sustain = tbl[i].sus; rel = tbl[i].rel; din = tbl[i].din;
            run(tbl[i].cyc);
            chk_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].amp, tbl[i].dout);
        end

        // Re-trigger: release from ATTACK at 100, resume attack from 90
        gate = 1'b1;
        run(1601);
        chk_out("retrig_att100", 1, 100, 4079 - 4079 + (4095 * 99) / 256);
        gate = 1'b0;
        run(1);
        chk("retrig_rel.state", int'(state), 4);
        chk("retrig_rel.amp", int'(amplitude), 100);
        run(160);
        chk("retrig_rel90.amp", int'(amplitude), 90);
        gate = 1'b1;
        run(1);
        chk("retrig_att90.state", int'(state), 1);
        chk("retrig_att90.amp", int'(amplitude), 90);
        run(16);
        chk("retrig_att91.amp", int'(amplitude), 91);

        // Continue to SUSTAIN at 136, then lower sustain and pin amp at 128
        decay = 4'd0;
        wait_until("reach_sustain", 1'b0, 3, 6000);
        chk("sustain136.amp", int'(amplitude), 136);
        sustain = 4'd7;
        wait_until("lower_to_128", 1'b1, 128, 500);
        sustain = 4'd15;
        run(300);
        chk("hold128.state", int'(state), 3);
        chk("hold128.amp", int'(amplitude), 128);
        din = 12'd4000;
        run(1);
        chk("scale4000.dout", int'(dout), 2000);
        din = 12'd1;
        run(1);
        chk("scale1.dout", int'(dout), 0);

        // Release to IDLE, then sustain=15 skips straight through DECAY
        gate = 1'b0;
        wait_until("release_idle", 1'b0, 0, 3000);
        gate = 1'b1;
        run(1);
        chk("s15_att.amp", int'(amplitude), 0);
        run(4080);
        chk("s15_decay.state", int'(state), 2);
        chk("s15_decay.amp", int'(amplitude), 255);
        run(1);
        chk("s15_sustain.state", int'(state), 3);
        chk("s15_sustain.amp", int'(amplitude), 255);

        // Asynchronous reset mid-operation, restart only after release
        din = 12'd4095;
        run(3);
        #2 rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0);
        run(5);
        chk_out("rst_held_gate", 0, 0, 0);
        sustain = 4'd0; decay = 4'd0;
        rst = 1'b0;
        run(1);
        chk("restart.state", int'(state), 1);

        // sustain=0: decays to zero but stays in SUSTAIN
        run(8160);
        chk("s0_decay.state", int'(state), 2);
        chk("s0_decay.amp", int'(amplitude), 0);
        run(1);
        chk("s0_sustain.state", int'(state), 3);
        run(100);
        chk("s0_hold.state", int'(state), 3);
        chk("s0_hold.amp", int'(amplitude), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
